mem_sync_master: RTL and testbench

//  Initiator side of the synchronous data-memory interface (a/din/dout/mread/mwrite).

---
 rtl/mem_sync_master.sv | 166 ++++++++++++++++
 tb/tb_mem_sync_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_master.sv
// Initiator for the synchronous word-organised data memory: byte-addressed load/store
// requests in, one memory cycle (or a read-modify-write pair) out, response held until taken.
module mem_sync_master #(
  parameter  int S  = 32,
  parameter  int L  = 256,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic [AW+1:0] req_addr,
  input  logic [S-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [S-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_a,
  output logic [S-1:0]  mem_din,
  input  logic [S-1:0]  mem_dout,
  output logic          mem_mread,
  output logic          mem_mwrite
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [1:0]      lane_q, lane_d;
  logic [S-1:0]    wdata_q, wdata_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [S-1:0]    mem_din_q, mem_din_d;
  logic [S-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            req_bad;
  logic            req_word_store;

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  endfunction

  // Halves are always aligned here, so shifting by 8*lane also yields 16*addr[1].
  function automatic logic [S-1:0] lane_extract(input logic [S-1:0] d, input logic [1:0] sz,
                                                input logic [1:0] ln);
    logic [S-1:0] sh;
    sh = d >> {ln, 3'b000};
    case (sz)
      2'b00:   return {{(S-8){1'b0}}, sh[7:0]};
      2'b01:   return {{(S-16){1'b0}}, sh[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [S-1:0] lane_merge(input logic [S-1:0] d, input logic [1:0] sz,
                                              input logic [1:0] ln, input logic [S-1:0] wd);
    logic [S-1:0] mask;
    logic [S-1:0] ins;
    if (sz == 2'b00) begin
      mask = {{(S-8){1'b0}}, 8'hFF};
      ins  = {{(S-8){1'b0}}, wd[7:0]};
    end else begin
      mask = {{(S-16){1'b0}}, 16'hFFFF};
      ins  = {{(S-16){1'b0}}, wd[15:0]};
    end
    mask = mask << {ln, 3'b000};
    ins  = ins << {ln, 3'b000};
    return (d & ~mask) | ins;
  endfunction

  assign req_bad        = is_bad(req_size, req_addr[1:0]);
  assign req_word_store = req_we && (req_size == 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_a_q     <= '0;
      mem_din_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_a_q     <= mem_a_d;
      mem_din_q   <= mem_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_bad)             state_d = RSP;
        else if (req_word_store) state_d = WR;
        else                     state_d = RD;
      end
      RD:  state_d = we_q ? WR : RSP;
      WR:  state_d = RSP;
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and datapath; mem_a/mem_din only change on accept or at the end of RD.
  always_comb begin
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_a_d     = mem_a_q;
    mem_din_d   = mem_din_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        lane_d  = req_addr[1:0];
        wdata_d = req_wdata;
        mem_a_d = req_addr[AW+1:2];
        if (req_bad) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (req_word_store) begin
          mem_din_d = req_wdata;
        end
      end
      RD: begin
        if (we_q) begin
          mem_din_d = lane_merge(mem_dout, size_q, lane_q, wdata_q);
        end else begin
          rsp_rdata_d = lane_extract(mem_dout, size_q, lane_q);
          rsp_err_d   = 1'b0;
        end
      end
      WR: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RSP);
    mem_mread  = (state_q == RD);
    mem_mwrite = (state_q == WR);
    rsp_rdata  = rsp_rdata_q;
    rsp_err    = rsp_err_q;
    mem_a      = mem_a_q;
    mem_din    = mem_din_q;
  end

endmodule

// File: tb/tb_mem_sync_master.sv
// Directed bench for mem_sync_master with a behavioural synchronous memory attached.
module tb_mem_sync_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_a;
  logic [31:0] mem_din, mem_dout;
  logic        mem_mread, mem_mwrite;

  logic [31:0] mem [256];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_rd_a, last_wr_a;
  logic [31:0] last_wr_din;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_sync_master #(.S(32), .L(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_mread(mem_mread), .mem_mwrite(mem_mwrite)
  );

  // Garbage on mem_dout outside read cycles exposes any use of it.
  assign mem_dout = mem_mread ? mem[mem_a] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_mwrite) begin
      mem[mem_a]  <= mem_din;
      wr_cnt      <= wr_cnt + 1;
      last_wr_a   <= mem_a;
      last_wr_din <= mem_din;
    end
    if (mem_mread) begin
      rd_cnt    <= rd_cnt + 1;
      last_rd_a <= mem_a;
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic [9:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    total++; if (mem_a !== 8'h0) begin bad++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
    total++; if (mem_din !== 32'h0) begin bad++; $display("FAIL rst_mem_din: got %h want 0", mem_din); end
    total++; if ({mem_mread, mem_mwrite} !== 2'b00) begin bad++; $display("FAIL rst_mem_en: got %b want 00", {mem_mread, mem_mwrite}); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 10'h100, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wst_latency: got %0d want 2", lat); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wst_wr_cycles: got %0d want 1", wr_cnt - w0); end
    total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL wst_rd_cycles: got %0d want 0", rd_cnt - r0); end
    total++; if (last_wr_a !== 8'h40) begin bad++; $display("FAIL wst_mem_a: got %h want 40", last_wr_a); end
    total++; if (last_wr_din !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_mem_din: got %h want deadbeef", last_wr_din); end
    total++; if ({er, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL wst_rsp: got %b/%h want 0/0", er, rd); end
    do_req(1'b0, 2'b10, 10'h100, 32'h0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wld_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wld_rdata: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wld_err: got %b want 0", er); end
    total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL wld_rd_cycles: got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_byte_rmw();
    logic [31:0] rd; logic er; int lat; int r0, w0;
    do_req(1'b1, 2'b10, 10'h100, 32'h11223344, rd, er, lat);
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b00, 10'h101, 32'h123456AA, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL bst_latency: got %0d want 3", lat); end
    total++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin bad++; $display("FAIL bst_cycles: got rd=%0d wr=%0d want 1/1", rd_cnt - r0, wr_cnt - w0); end
    total++; if (last_rd_a !== 8'h40 || last_wr_a !== 8'h40) begin bad++; $display("FAIL bst_mem_a: got rd=%h wr=%h want 40", last_rd_a, last_wr_a); end
    total++; if (last_wr_din !== 32'h1122AA44) begin bad++; $display("FAIL bst_mem_din: got %h want 1122aa44", last_wr_din); end
    total++; if (mem[8'h40] !== 32'h1122AA44) begin bad++; $display("FAIL bst_mem_word: got %h want 1122aa44", mem[8'h40]); end
  endtask

  task automatic test_sub_load();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 2'b01, 10'h102, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00001122) begin bad++; $display("FAIL hld_102: got %h want 00001122", rd); end
    do_req(1'b0, 2'b00, 10'h101, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL bld_101: got %h want 000000aa", rd); end
    do_req(1'b0, 2'b00, 10'h103, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000011) begin bad++; $display("FAIL bld_103: got %h want 00000011", rd); end
    do_req(1'b0, 2'b01, 10'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000AA44) begin bad++; $display("FAIL hld_100: got %h want 0000aa44", rd); end
    do_req(1'b1, 2'b01, 10'h102, 32'h9876BEEF, rd, er, lat);
    total++; if (lat !== 3 || last_wr_din !== 32'hBEEFAA44) begin bad++; $display("FAIL hst_102: got lat=%0d din=%h want 3/beefaa44", lat, last_wr_din); end
    do_req(1'b0, 2'b10, 10'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hBEEFAA44) begin bad++; $display("FAIL hst_readback: got %h want beefaa44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 2'b10, 10'h002, 32'h0, rd, er, lat);
    total++; if ({er, rd} !== {1'b1, 32'h0} || lat !== 1) begin bad++; $display("FAIL err_word_mis: got err=%b rd=%h lat=%0d want 1/0/1", er, rd, lat); end
    do_req(1'b1, 2'b01, 10'h003, 32'hFFFF, rd, er, lat);
    total++; if ({er, rd} !== {1'b1, 32'h0} || lat !== 1) begin bad++; $display("FAIL err_half_mis: got err=%b rd=%h lat=%0d want 1/0/1", er, rd, lat); end
    do_req(1'b0, 2'b11, 10'h100, 32'h0, rd, er, lat);
    total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_size11: got err=%b rd=%h want 1/0", er, rd); end
    total++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL err_no_mem: got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0); end
    do_req(1'b0, 2'b00, 10'h101, 32'h0, rd, er, lat);
    total++; if ({er, rd} !== {1'b0, 32'h000000AA}) begin bad++; $display("FAIL err_clears: got err=%b rd=%h want 0/000000aa", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int w0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 10'h100; req_wdata = '0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 10'h104; req_wdata = 32'hCAFEF00D;
    w0 = wr_cnt;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL bp_hold%0d: got v=%b rdy=%b rd=%h want 1/0/beefaa44", i, rsp_valid, req_ready, rsp_rdata); end
      @(posedge clk); #1;
    end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL bp_no_accept: got wr=%0d want 0", wr_cnt - w0); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if ({req_ready, mem_mwrite} !== 2'b01) begin bad++; $display("FAIL bp_accept_after: got rdy=%b mw=%b want 0/1", req_ready, mem_mwrite); end
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req(1'b0, 2'b10, 10'h104, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL bp_store_done: got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] rd; logic er; int lat; int w0;
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h100; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (mem_mwrite !== 1'b1) begin bad++; $display("FAIL rwr_in_wr: got mw=%b want 1", mem_mwrite); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_mwrite !== 1'b0) begin bad++; $display("FAIL rwr_mwrite_drop: got %b want 0", mem_mwrite); end
    total++; if ({rsp_valid, rsp_err, mem_mread} !== 3'b000 || rsp_rdata !== 32'h0 || mem_a !== 8'h0 || mem_din !== 32'h0) begin bad++; $display("FAIL rwr_outputs: got v=%b e=%b mr=%b rd=%h a=%h din=%h want all 0", rsp_valid, rsp_err, mem_mread, rsp_rdata, mem_a, mem_din); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL rwr_release: got rdy=%b wr=%0d want 1/0", req_ready, wr_cnt - w0); end
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 10'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hBEEFAA44) begin bad++; $display("FAIL rwr_readback: got %h want beefaa44", rd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    @(posedge clk); #1;
    test_word();
    test_byte_rmw();
    test_sub_load();
    test_errors();
    test_backpressure();
    test_reset_mid_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
